fp_mul_norm_round: RTL

Downstream stage of the 24x24 mantissa multiplier in the single-precision FP multiply path. It consumes the 48-bit mantissa product, the sum of the biased exponents, the result sign and the special-case flags. It then normalizes, rounds to nearest-even, handles overflow, underflow and special cases, and packs an IEEE754 binary32 result. It is a 2-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/fp_mul_norm_round.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fp_mul_norm_round.sv
// Normalize, round-to-nearest-even and pack a 48-bit FP32 mantissa product.
// Latency 2 cycles: stage 1 normalizes, stage 2 rounds and packs.
// Backpressure: valid/ready on both sides, 1 bundle/cycle, outputs held while stalled.
module fp_mul_norm_round #(
    parameter int          EXP_BIAS = 127,
    parameter logic [31:0] QNAN     = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [8:0]  in_exp_sum,
    input  logic [47:0] in_prod,
    input  logic        in_zero,
    input  logic        in_inf,
    input  logic        in_nan,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags
);

    // Stage 1 state: normalized mantissa, rounding bits, unbiased-adjusted exponent
    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_q, s1_sign_d;
    logic [9:0]  s1_exp_q, s1_exp_d;     // two's-complement signed exponent
    logic [22:0] s1_mant_q, s1_mant_d;
    logic        s1_guard_q, s1_guard_d;
    logic        s1_sticky_q, s1_sticky_d;
    logic        s1_zero_q, s1_zero_d;
    logic        s1_inf_q, s1_inf_d;
    logic        s1_nan_q, s1_nan_d;

    // Stage 2 state: packed result
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] out_result_q, out_result_d;
    logic [3:0]  out_flags_q, out_flags_d;

    logic        s1_adv;
    logic        s2_adv;
    logic [9:0]  exp_ext;
    logic        round_up;
    logic [23:0] mant_sum;
    logic [22:0] mant_r;
    logic [9:0]  exp_r;
    logic [31:0] res_c;
    logic [3:0]  flags_c;

    // Pipeline advance conditions; stage 1 can accept whenever stage 2 drains
    always_comb begin
        s2_adv = !s2_valid_q || out_ready;
        s1_adv = !s1_valid_q || s2_adv;
    end

    assign in_ready   = s1_adv;
    assign out_valid  = s2_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;
    assign exp_ext    = {1'b0, in_exp_sum};

    // Stage 1: pick the mantissa window from the product's leading bit position
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_exp_d    = s1_exp_q;
        s1_mant_d   = s1_mant_q;
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
        s1_zero_d   = s1_zero_q;
        s1_inf_d    = s1_inf_q;
        s1_nan_d    = s1_nan_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = in_sign;
                s1_inf_d  = in_inf;
                s1_nan_d  = in_nan;
                // A zero product with no special flag behaves as a zero operand
                s1_zero_d = in_zero || ((in_prod == 48'd0) && !in_inf && !in_nan);
                if (in_prod[47]) begin
                    s1_mant_d   = in_prod[46:24];
                    s1_guard_d  = in_prod[23];
                    s1_sticky_d = |in_prod[22:0];
                    s1_exp_d    = exp_ext - 10'(EXP_BIAS - 1);
                end else begin
                    s1_mant_d   = in_prod[45:23];
                    s1_guard_d  = in_prod[22];
                    s1_sticky_d = |in_prod[21:0];
                    s1_exp_d    = exp_ext - 10'(EXP_BIAS);
                end
            end
        end
    end

    // Round to nearest-even, then resolve specials and range limits by priority
    always_comb begin
        round_up = s1_guard_q && (s1_sticky_q || s1_mant_q[0]);
        mant_sum = {1'b0, s1_mant_q} + 24'(round_up);
        // A carry out leaves mant_sum[22:0] at zero, i.e. 1.0 x 2^(exp+1)
        mant_r   = mant_sum[22:0];
        exp_r    = s1_exp_q + 10'(mant_sum[23]);
        res_c    = {s1_sign_q, exp_r[7:0], mant_r};
        flags_c  = {3'b000, s1_guard_q || s1_sticky_q};
        if (s1_nan_q || (s1_inf_q && s1_zero_q)) begin
            res_c   = QNAN;
            flags_c = 4'b1000;
        end else if (s1_inf_q) begin
            res_c   = {s1_sign_q, 8'hFF, 23'd0};
            flags_c = 4'b0000;
        end else if (s1_zero_q) begin
            res_c   = {s1_sign_q, 31'd0};
            flags_c = 4'b0000;
        end else if ($signed(exp_r) >= 10'sd255) begin
            res_c   = {s1_sign_q, 8'hFF, 23'd0};
            flags_c = 4'b0101;
        end else if ($signed(exp_r) <= 10'sd0) begin
            res_c   = {s1_sign_q, 31'd0};
            flags_c = 4'b0011;
        end
    end

    // Stage 2 output register: load when draining, otherwise hold
    always_comb begin
        s2_valid_d   = s2_valid_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_result_d = res_c;
                out_flags_d  = flags_c;
            end
        end
    end

    // State registers with synchronous reset that discards in-flight bundles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= 10'd0;
            s1_mant_q    <= 23'd0;
            s1_guard_q   <= 1'b0;
            s1_sticky_q  <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_inf_q     <= 1'b0;
            s1_nan_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_result_q <= 32'd0;
            out_flags_q  <= 4'd0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_exp_q     <= s1_exp_d;
            s1_mant_q    <= s1_mant_d;
            s1_guard_q   <= s1_guard_d;
            s1_sticky_q  <= s1_sticky_d;
            s1_zero_q    <= s1_zero_d;
            s1_inf_q     <= s1_inf_d;
            s1_nan_q     <= s1_nan_d;
            s2_valid_q   <= s2_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
        end
    end

endmodule
